rojobot_sysreg_capture: RTL

ROJOBOT_SYSREG_CAPTURE -- requirements
Module: rojobot_sysreg_capture

---
 rtl/rojobot_pkg.sv | 26 ++
 rtl/rojobot_sysreg_capture_if.sv | 27 ++
 rtl/rojobot_edge_det.sv | 24 ++
 rtl/rojobot_sysreg_capture.sv | 106 ++++++++++
 4 files changed

// File: rtl/rojobot_pkg.sv
// Shared types and constants for the rojobot system-register capture block:
// FSM encoding, register byte width and snapshot field offsets.
package rojobot_pkg;

   localparam int unsigned REG_W       = 8;
   localparam int unsigned LOCX_LSB    = 24;
   localparam int unsigned LOCY_LSB    = 16;
   localparam int unsigned SENSORS_LSB = 8;
   localparam int unsigned BOTINFO_LSB = 0;

   // Plain 1-bit state constants keep the encoding visible to legacy tools
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE    = 1'b0;
   localparam state_t ST_PENDING = 1'b1;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'h01;
      end
      return result;
   endfunction

endpackage

// File: rtl/rojobot_sysreg_capture_if.sv
// Bus between the rojobot register source/consumer and the capture block.
// The slave modport is the capture block; master is the surrounding system.
interface rojobot_sysreg_capture_if;

   logic                               upd_sysregs;
   logic [rojobot_pkg::REG_W-1:0]      LocX_reg;
   logic [rojobot_pkg::REG_W-1:0]      LocY_reg;
   logic [rojobot_pkg::REG_W-1:0]      Sensors_reg;
   logic [rojobot_pkg::REG_W-1:0]      BotInfo_reg;
   logic                               io_ack;
   logic                               io_update;
   logic [4*rojobot_pkg::REG_W-1:0]    botinfo_out;
   logic                               moved;
   logic [7:0]                         overrun_cnt;
   logic                               stale;

   modport master (
      output upd_sysregs, LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg, io_ack,
      input  io_update, botinfo_out, moved, overrun_cnt, stale
   );

   modport slave (
      input  upd_sysregs, LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg, io_ack,
      output io_update, botinfo_out, moved, overrun_cnt, stale
   );

endinterface

// File: rtl/rojobot_edge_det.sv
// Registered 1-bit rising-edge detector: flags the edge where the input is
// high and its registered copy is still low.
module rojobot_edge_det (
   input  logic clk_in,
   input  logic reset,
   input  logic strobe,
   output logic rise
);

   logic strobe_r;

   // Previous-edge copy of the strobe; cleared by reset so a level already
   // high at release still counts as a rising edge.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         strobe_r <= 1'b0;
      end else begin
         strobe_r <= strobe;
      end
   end

   assign rise = strobe & ~strobe_r;

endmodule

// File: rtl/rojobot_sysreg_capture.sv
// Snapshots the four rojobot system registers on each update strobe and holds
// them for a consumer, tracking movement, overruns and update staleness.
module rojobot_sysreg_capture
   import rojobot_pkg::*;
#(
   parameter logic [31:0] STALE_CYCLES = 32'd5_000_000
) (
   input  logic                     clk_in,
   input  logic                     reset,
   rojobot_sysreg_capture_if.slave  bus
);

   logic                 capture_s;
   state_t               state_r;
   state_t               state_nxt_s;
   logic [4*REG_W-1:0]   snap_r;
   logic [4*REG_W-1:0]   snap_new_s;
   logic                 moved_r;
   logic                 moved_nxt_s;
   logic [7:0]           overrun_r;
   logic                 overrun_inc_s;
   logic [31:0]          idle_r;
   logic [31:0]          idle_nxt_s;
   logic                 stale_r;

   rojobot_edge_det u_edge_det (
      .clk_in (clk_in),
      .reset  (reset),
      .strobe (bus.upd_sysregs),
      .rise   (capture_s)
   );

   // Next-state, snapshot and idle-counter computation
   always_comb begin
      snap_new_s = {bus.LocX_reg, bus.LocY_reg, bus.Sensors_reg, bus.BotInfo_reg};
      moved_nxt_s = (bus.LocX_reg != snap_r[LOCX_LSB +: REG_W]) ||
                    (bus.LocY_reg != snap_r[LOCY_LSB +: REG_W]);
      // An ack in the capture cycle consumes the old snapshot, so no overrun
      overrun_inc_s = (state_r == ST_PENDING) && capture_s && !bus.io_ack;

      if (capture_s) begin
         idle_nxt_s = 32'd0;
      end else if (idle_r == STALE_CYCLES) begin
         idle_nxt_s = idle_r;
      end else begin
         idle_nxt_s = idle_r + 32'd1;
      end

      case (state_r)
         ST_IDLE: begin
            if (capture_s) begin
               state_nxt_s = ST_PENDING;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PENDING: begin
            if (capture_s) begin
               state_nxt_s = ST_PENDING;
            end else if (bus.io_ack) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_PENDING;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, snapshot and status registers
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         snap_r    <= 32'd0;
         moved_r   <= 1'b0;
         overrun_r <= 8'd0;
         idle_r    <= 32'd0;
         stale_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         idle_r  <= idle_nxt_s;
         stale_r <= (idle_nxt_s == STALE_CYCLES) && !capture_s;
         if (capture_s) begin
            snap_r  <= snap_new_s;
            moved_r <= moved_nxt_s;
         end else begin
            snap_r  <= snap_r;
            moved_r <= moved_r;
         end
         if (overrun_inc_s) begin
            overrun_r <= sat_inc8(overrun_r);
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

   assign bus.io_update   = (state_r == ST_PENDING);
   assign bus.botinfo_out = snap_r;
   assign bus.moved       = moved_r;
   assign bus.overrun_cnt = overrun_r;
   assign bus.stale       = stale_r;

endmodule
